// File: rtl/led_drv_pkg.sv
// Shared defaults and helpers for the LED activity driver.
package led_drv_pkg;

  // Defaults derived from a 25 MHz clock: 10 us timebase, 50 ms hold.
  localparam int unsigned PRESCALE_DEF = 250;
  localparam int unsigned HOLD_DEF     = 5000;

  // Bits needed to hold values 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: stretches a strobe into HOLD timebase ticks of activity.
module led_stretch_ch
  import led_drv_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  input  logic tick,
  output logic active
);

  localparam int unsigned HcntW = clog2(HOLD + 1);

  logic [HcntW-1:0] r_hcnt;

  // Hold counter: reload beats decrement, decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
    end else if (ev) begin
      r_hcnt <= HcntW'(HOLD);
    end else if (tick && (r_hcnt != '0)) begin
      r_hcnt <= r_hcnt - HcntW'(1);
    end
  end

  assign active = (r_hcnt != '0);

endmodule

// File: rtl/led_activity_drv.sv
// Drives NCH LEDs from activity strobes with stretched on-time and shared PWM dimming.
module led_activity_drv
  import led_drv_pkg::*;
#(
  parameter int unsigned NCH      = 8,
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  parameter int unsigned HOLD     = HOLD_DEF,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      ev_i,
  input  logic [PWM_BITS-1:0] bright_i,
  output logic [NCH-1:0]      led_o,
  output logic                busy_o
);

  localparam int unsigned PcntW = clog2(PRESCALE);

  logic [PcntW-1:0]    r_pcnt;
  logic [PWM_BITS-1:0] r_wcnt;
  logic                w_tick;
  logic [NCH-1:0]      w_active;
  logic                w_pwm_on;

  assign w_tick = (r_pcnt == PcntW'(PRESCALE - 1));

  // Timebase prescaler and PWM phase counter; the PWM advances once per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_wcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_wcnt <= r_wcnt + PWM_BITS'(1);
    end else begin
      r_pcnt <= r_pcnt + PcntW'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    led_stretch_ch #(
      .HOLD(HOLD)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ev    (ev_i[g]),
      .tick  (w_tick),
      .active(w_active[g])
    );
  end

  // All-ones brightness forces full-on, since wcnt < max misses one phase.
  assign w_pwm_on = (bright_i == '1) | (r_wcnt < bright_i);
  assign led_o    = w_active & {NCH{w_pwm_on}};
  assign busy_o   = |w_active;

endmodule

// File: tb/tb_led_activity_drv.sv
// Self-checking bench for led_activity_drv against a tick-counting reference model.
module tb_led_activity_drv;

  localparam int NCH      = 4;
  localparam int PRESCALE = 4;
  localparam int HOLD     = 3;
  localparam int PWM_BITS = 2;

  logic                clk;
  logic                rst;
  logic [NCH-1:0]      ev_i;
  logic [PWM_BITS-1:0] bright_i;
  logic [NCH-1:0]      led_o;
  logic                busy_o;

  led_activity_drv #(
    .NCH     (NCH),
    .PRESCALE(PRESCALE),
    .HOLD    (HOLD),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_i    (ev_i),
    .bright_i(bright_i),
    .led_o   (led_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edges are numbered from 0 after reset; edge k is a tick when (k+1) % PRESCALE == 0.
  int e = -1;
  int last_ev [NCH];
  bit seen    [NCH];

  function automatic int ticks_upto(input int k);
    return (k + 1) / PRESCALE;
  endfunction

  task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic step(input logic [NCH-1:0] ev, input logic [PWM_BITS-1:0] br, input logic r);
    logic [NCH-1:0] exp_act;
    logic           pwm;
    int             wcnt;
    ev_i     = ev;
    bright_i = br;
    rst      = r;
    @(posedge clk);
    if (r) begin
      e = -1;
      for (int i = 0; i < NCH; i++) seen[i] = 1'b0;
    end else begin
      e++;
      for (int i = 0; i < NCH; i++) if (ev[i]) begin
        seen[i]    = 1'b1;
        last_ev[i] = e;
      end
    end
    #1;
    for (int i = 0; i < NCH; i++)
      exp_act[i] = seen[i] && ((ticks_upto(e) - ticks_upto(last_ev[i])) < HOLD);
    wcnt = ticks_upto(e) % (1 << PWM_BITS);
    pwm  = (int'(br) == (1 << PWM_BITS) - 1) || (wcnt < int'(br));
    check("led_o", led_o, exp_act & {NCH{pwm}});
    check("busy_o", {{(NCH-1){1'b0}}, busy_o}, {{(NCH-1){1'b0}}, |exp_act});
  endtask

  initial begin
    int on_cnt;
    ev_i     = '0;
    bright_i = '1;
    rst      = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      seen[i]    = 1'b0;
      last_ev[i] = 0;
    end

    // Reset with all strobes high: nothing may light.
    repeat (3) step(4'hF, 2'd3, 1'b1);
    step(4'h0, 2'd3, 1'b0);

    // Single strobe on a tick edge (edges 0..2 elapsed, edge 3 is a tick).
    repeat (2) step(4'h0, 2'd3, 1'b0);
    step(4'h1, 2'd3, 1'b0);
    on_cnt = led_o[0] ? 1 : 0;
    repeat (16) begin
      step(4'h0, 2'd3, 1'b0);
      if (led_o[0]) on_cnt++;
    end
    n_checks++;
    assert (on_cnt == 12) else begin
      n_fail++;
      $error("FAIL single_on_time: observed %0d expected %0d", on_cnt, 12);
    end

    // Retrigger 8 clocks after the first strobe.
    step(4'h1, 2'd3, 1'b0);
    repeat (7) step(4'h0, 2'd3, 1'b0);
    step(4'h1, 2'd3, 1'b0);
    repeat (16) step(4'h0, 2'd3, 1'b0);

    // PWM on channel 1 held high at several brightness levels.
    repeat (32) step(4'h2, 2'd1, 1'b0);
    repeat (16) step(4'h2, 2'd0, 1'b0);
    repeat (16) step(4'h2, 2'd3, 1'b0);
    repeat (16) step(4'h2, 2'd2, 1'b0);
    repeat (16) step(4'h0, 2'd3, 1'b0);

    // Reset mid-hold on channel 2.
    step(4'h4, 2'd3, 1'b0);
    repeat (2) step(4'h0, 2'd3, 1'b0);
    step(4'h4, 2'd3, 1'b1);
    repeat (20) step(4'h0, 2'd3, 1'b0);

    // Independent channels strobed 5 clocks apart.
    step(4'h1, 2'd3, 1'b0);
    repeat (4) step(4'h0, 2'd3, 1'b0);
    step(4'h8, 2'd3, 1'b0);
    repeat (20) step(4'h0, 2'd3, 1'b0);

    // Randomized sparse strobes, brightness changes and occasional resets.
    repeat (400) begin
      logic [NCH-1:0] rev;
      for (int i = 0; i < NCH; i++) rev[i] = ($urandom_range(0, 7) == 0);
      step(rev, PWM_BITS'($urandom_range(0, 3)), ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_activity_drv.md
Name: led_activity_drv

Overview:
- Output-side counterpart to the button/switch input conditioning. Drives NCH board LEDs from internal single-clock activity strobes.
- Each short strobe is stretched into a human-visible on-time, retriggered by later strobes.
- All LEDs are gated by a shared PWM brightness control.
- Sits between core status logic (bus activity, IRQ, error flags) and the FPGA LED pins; default timing targets a 25MHz clock.

Parameters:
- NCH, 8, number of LED channels.
- PRESCALE, 250, clocks per timebase tick (10us at 25MHz).
- HOLD, 5000, ticks of on-time after the last strobe (50ms).
- PWM_BITS, 4, width of PWM counter and brightness input.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ev_i  in  NCH  activity strobes. Synchronous to clk, any width; a high level holds the channel in the reloaded state.
- bright_i  in  PWM_BITS  global brightness. 0 = off; all-ones = fully on.
- led_o  out  NCH  LED drive, active-high.
- busy_o  out  1  OR of all channel-active flags.

Behaviour:
- Registered state:
  - prescale counter pcnt, 0..PRESCALE-1;
  - PWM counter wcnt, PWM_BITS wide;
  - per-channel hold counter hcnt[i], width clog2(HOLD+1).
- Reset: pcnt=0, wcnt=0, all hcnt=0, so led_o=0 and busy_o=0 in the cycle after rst is sampled high. rst asserted mid-hold clears all state at the next edge; rst has priority over ev_i.
- Tick: tick=1 when pcnt==PRESCALE-1. pcnt wraps to 0 on a tick, else increments.
- wcnt increments on each tick and wraps modulo 2^PWM_BITS.
- Per channel, in priority order each clk:
  - ev_i[i]=1: hcnt[i] <= HOLD. Reload wins over a simultaneous tick.
  - else tick and hcnt[i]!=0: hcnt[i] <= hcnt[i]-1.
  - else hold.
- hcnt[i] saturates at 0; it never wraps.
- active[i] = (hcnt[i]!=0).
- pwm_on = (bright_i == all-ones) | (wcnt < bright_i), unsigned compare.
- led_o[i] = active[i] & pwm_on, formed only from registered state plus bright_i; no other combinational path from ev_i.
- Latency: ev_i high at edge n gives led_o high from cycle n+1 (when pwm_on).
- On-time after the last strobe at edge n: between (HOLD-1)*PRESCALE+1 and HOLD*PRESCALE clocks, depending on tick phase. It is exactly HOLD*PRESCALE clocks when the strobe coincides with a tick.
- busy_o = OR over active[i], unaffected by PWM.
- bright_i changes take effect in the same cycle; no resync.
- ev_i needs no synchronizer or debounce: its producers are on clk.
- Channels are fully independent; every channel shares one pcnt and one wcnt.

Decomposition:
- Package led_drv_pkg holds:
  - default parameter constants (25MHz-derived PRESCALE, HOLD);
  - a clog2 function for counter widths.
- Sub-module led_stretch_ch: one channel's hold counter plus reload/decrement logic.
  - Inputs: clk, rst, ev, tick.
  - Output: active.
  - Instantiated NCH times by generate.
- The top holds the prescaler, PWM counter and output gating.

Test Plan:
- Bench parameters for all cases: NCH=4, PRESCALE=4, HOLD=3, PWM_BITS=2.
- Reset: rst=1 for 3 clks with ev_i=4'hF, bright_i=3 -> led_o=0, busy_o=0 throughout; state is zero one clk after rst falls.
- Single strobe on tick: ev_i[0] pulsed 1 clk at cycle n where pcnt==3, bright_i=3 -> led_o[0]=1 for exactly 12 clks (n+1..n+12), busy_o likewise; other bits stay 0.
- Retrigger: second 1-clk strobe on ch0 8 clks after the first -> on-time extends; led_o[0] stays high continuously until 9..12 clks after the second strobe; no gap.
- PWM: ev_i[1] held high, bright_i=1 -> led_o[1] high only while wcnt==0, i.e. 4 of every 16 clks. bright_i=0 -> never high. bright_i=3 -> always high.
- Reset mid-hold: strobe ch2, assert rst 3 clks later -> led_o[2]=0 and busy_o=0 from the next cycle; no residual on-time after rst drops.
- Independence: ch0 and ch3 strobed 5 clks apart -> each ends per its own strobe time; busy_o drops only after the later channel ends.
